control_unit: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 61 ++++++
 rtl/alu_lane_decoder.sv | 48 ++++
 rtl/control_unit.sv | 86 ++++++++
 tb/tb_control_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the dual-lane ALU control decoder.
// Holds the RISC-V opcode and funct3 constants, the funct7 alternate-op bit
// position, the 3-bit ALU operation enum and the funct3-to-op helper.
package alu_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned CTRL_W   = 2 * ALU_OP_W;

  // Opcode constants
  localparam logic [OPCODE_W-1:0] OPC_RTYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_ITYPE = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_JALR  = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_NOP   = 7'b0000000;

  // funct3 constants
  localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_XOR     = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_OR      = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_AND     = 3'b111;

  // funct7 bit selecting SUB / SRA
  localparam int unsigned F7_ALT_BIT = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_SRL = 3'b011,
    ALU_SRA = 3'b100,
    ALU_XOR = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_op_e;

  // Map funct3 to an ALU op. sub_ok gates the SUB alternate, which only
  // register-register instructions may select; SRA is always selectable.
  function automatic alu_op_e funct3_op(input logic [FUNCT3_W-1:0] f3,
                                        input logic                alt,
                                        input logic                sub_ok);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD_SUB: op = (sub_ok && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;  // SLT/SLTU fall back to ADD
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_lane_decoder.sv
// Single-lane ALU control decoder (purely combinational).
// Ports:
//   opcode_i [6:0]  instruction opcode
//   funct3_i [2:0]  funct3 field
//   funct7_i [6:0]  funct7 field (only the alternate-op bit is used)
//   op_c_o          decoded ALU operation
//   src_c_o         operand B source: 0 = register, 1 = immediate
module alu_lane_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic [FUNCT7_W-1:0] funct7_i,
  output alu_op_e             op_c_o,
  output logic                src_c_o
);

  logic alt;
  logic unused_funct7;

  assign alt           = funct7_i[F7_ALT_BIT];
  assign unused_funct7 = ^{funct7_i[FUNCT7_W-1:F7_ALT_BIT+1], funct7_i[F7_ALT_BIT-1:0]};

  // Opcode class decode; unknown opcodes (incl. NOP) behave as ADD on registers
  always_comb begin
    op_c_o  = ALU_ADD;
    src_c_o = 1'b0;
    case (opcode_i)
      OPC_RTYPE: begin
        op_c_o  = funct3_op(funct3_i, alt, 1'b1);
        src_c_o = 1'b0;
      end
      OPC_ITYPE: begin
        op_c_o  = funct3_op(funct3_i, alt, 1'b0);
        src_c_o = 1'b1;
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        op_c_o  = ALU_ADD;
        src_c_o = 1'b1;
      end
      default: begin
        op_c_o  = ALU_ADD;
        src_c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Dual-lane ALU control decoder with registered outputs.
// Decodes lane A and lane B instructions; in unified mode lane A drives both
// halves, in split mode each lane decodes independently. One cycle latency.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   opcodeA/B, funct3A/B,    per-lane instruction fields
//   funct7A/B
//   mode                     1 = unified, 0 = split
//   ALUOpA/B                 per-lane ALU op (registered)
//   ALUCtrl                  {ALUOpA, ALUOpB}
//   ALUSrcA/B                per-lane operand source (registered)
module control_unit
  import alu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcodeA,
  input  logic [OPCODE_W-1:0] opcodeB,
  input  logic [FUNCT3_W-1:0] funct3A,
  input  logic [FUNCT3_W-1:0] funct3B,
  input  logic [FUNCT7_W-1:0] funct7A,
  input  logic [FUNCT7_W-1:0] funct7B,
  input  logic                mode,
  output logic [ALU_OP_W-1:0] ALUOpA,
  output logic [ALU_OP_W-1:0] ALUOpB,
  output logic [CTRL_W-1:0]   ALUCtrl,
  output logic                ALUSrcA,
  output logic                ALUSrcB
);

  alu_op_e dec_op_a, dec_op_b;
  logic    dec_src_a, dec_src_b;

  alu_op_e op_a_d, op_b_d, op_a_q, op_b_q;
  logic    src_a_d, src_b_d, src_a_q, src_b_q;

  alu_lane_decoder u_dec_a (
    .opcode_i (opcodeA),
    .funct3_i (funct3A),
    .funct7_i (funct7A),
    .op_c_o   (dec_op_a),
    .src_c_o  (dec_src_a)
  );

  alu_lane_decoder u_dec_b (
    .opcode_i (opcodeB),
    .funct3_i (funct3B),
    .funct7_i (funct7B),
    .op_c_o   (dec_op_b),
    .src_c_o  (dec_src_b)
  );

  // Mode mux: unified mode replicates lane A onto lane B
  always_comb begin
    op_a_d  = dec_op_a;
    src_a_d = dec_src_a;
    op_b_d  = dec_op_b;
    src_b_d = dec_src_b;
    if (mode) begin
      op_b_d  = dec_op_a;
      src_b_d = dec_src_a;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q  <= ALU_ADD;
      op_b_q  <= ALU_ADD;
      src_a_q <= 1'b0;
      src_b_q <= 1'b0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
    end
  end

  assign ALUOpA  = op_a_q;
  assign ALUOpB  = op_b_q;
  assign ALUCtrl = {op_a_q, op_b_q};
  assign ALUSrcA = src_a_q;
  assign ALUSrcB = src_b_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcodeA, opcodeB;
  logic [2:0] funct3A, funct3B;
  logic [6:0] funct7A, funct7B;
  logic       mode;
  logic [2:0] ALUOpA, ALUOpB;
  logic [5:0] ALUCtrl;
  logic       ALUSrcA, ALUSrcB;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       sa;
    logic       sb;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] NP = 7'b0000000;
  localparam logic [6:0] F0 = 7'b0000000;
  localparam logic [6:0] F1 = 7'b0100000;

  control_unit dut (
    .clk     (clk),
    .rst     (rst),
    .opcodeA (opcodeA),
    .opcodeB (opcodeB),
    .funct3A (funct3A),
    .funct3B (funct3B),
    .funct7A (funct7A),
    .funct7B (funct7B),
    .mode    (mode),
    .ALUOpA  (ALUOpA),
    .ALUOpB  (ALUOpB),
    .ALUCtrl (ALUCtrl),
    .ALUSrcA (ALUSrcA),
    .ALUSrcB (ALUSrcB)
  );

  always #5 clk = ~clk;

  // Reference lane decode: returns {op, src}
  function automatic logic [3:0] ref_lane(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7);
    logic [2:0] op;
    op = 3'd0;
    if (opc == R || opc == I) begin
      case (f3)
        3'd0: op = (opc == R && f7[5]) ? 3'd1 : 3'd0;
        3'd1: op = 3'd2;
        3'd4: op = 3'd5;
        3'd5: op = f7[5] ? 3'd4 : 3'd3;
        3'd6: op = 3'd6;
        3'd7: op = 3'd7;
        default: op = 3'd0;
      endcase
      return {op, (opc == I)};
    end
    if (opc == LD || opc == ST || opc == JR) return 4'b0001;
    return 4'b0000;
  endfunction

  // Drive one vector at the falling edge and queue its expectation
  task automatic drive(input logic m,
                       input logic [6:0] oa, input logic [2:0] fa, input logic [6:0] sa7,
                       input logic [6:0] ob, input logic [2:0] fb, input logic [6:0] sb7,
                       input logic [2:0] ea, input logic [2:0] eb,
                       input logic esa, input logic esb, input string nm);
    exp_t e;
    @(negedge clk);
    mode = m;
    opcodeA = oa; funct3A = fa; funct7A = sa7;
    opcodeB = ob; funct3B = fb; funct7B = sb7;
    e.a = ea; e.b = eb; e.sa = esa; e.sb = esb;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mode = 1'b1;
    opcodeA = R; funct3A = 3'd0; funct7A = F1;
    opcodeB = NP; funct3B = 3'd0; funct7B = F0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ALUOpA, ALUOpB, ALUCtrl, ALUSrcA, ALUSrcB} !== 14'd0) begin
      errors++; $display("FAIL reset_initial outputs=%b exp=0", {ALUOpA, ALUOpB, ALUCtrl, ALUSrcA, ALUSrcB});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ALUOpA !== 3'b001 || ALUCtrl !== 6'b001001) begin
      errors++; $display("FAIL reset_first_decode ALUOpA=%b ALUCtrl=%b exp=001/001001", ALUOpA, ALUCtrl);
    end
    // Mid-cycle assertion must clear outputs without a clock edge
    @(negedge clk); #2 rst = 1'b1;
    #1;
    checks++;
    if ({ALUOpA, ALUOpB, ALUCtrl, ALUSrcA, ALUSrcB} !== 14'd0) begin
      errors++; $display("FAIL reset_async outputs=%b exp=0", {ALUOpA, ALUOpB, ALUCtrl, ALUSrcA, ALUSrcB});
    end
    @(posedge clk); #1;
    checks++;
    if (ALUCtrl !== 6'd0 || ALUOpA !== 3'd0) begin
      errors++; $display("FAIL reset_hold ALUCtrl=%b exp=000000", ALUCtrl);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ALUOpA !== 3'b001) begin
      errors++; $display("FAIL reset_release ALUOpA=%b exp=001", ALUOpA);
    end
  endtask

  task automatic test_unified_rtype;
    exp_t e; string nm;
    for (int i = 0; i < 2; i++) begin
      case (i)
        0: drive(1, R, 3'd0, F0, NP, 3'd0, F0, 3'd0, 3'd0, 0, 0, "uni_add");
        default: drive(1, R, 3'd0, F1, NP, 3'd0, F0, 3'd1, 3'd1, 0, 0, "uni_sub");
      endcase
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL scoreboard_empty"); end
      else begin
        e = sb_q.pop_front(); nm = name_q.pop_front(); checks += 5;
        if (ALUOpA !== e.a) begin errors++; $display("FAIL %s ALUOpA got=%b exp=%b", nm, ALUOpA, e.a); end
        if (ALUOpB !== e.b) begin errors++; $display("FAIL %s ALUOpB got=%b exp=%b", nm, ALUOpB, e.b); end
        if (ALUCtrl !== {e.a, e.b}) begin errors++; $display("FAIL %s ALUCtrl got=%b exp=%b", nm, ALUCtrl, {e.a, e.b}); end
        if (ALUSrcA !== e.sa) begin errors++; $display("FAIL %s ALUSrcA got=%b exp=%b", nm, ALUSrcA, e.sa); end
        if (ALUSrcB !== e.sb) begin errors++; $display("FAIL %s ALUSrcB got=%b exp=%b", nm, ALUSrcB, e.sb); end
      end
    end
  endtask

  task automatic test_unified_imm;
    exp_t e; string nm;
    for (int i = 0; i < 4; i++) begin
      // Lane B carries an R-type SUB that unified mode must ignore
      case (i)
        0: drive(1, I,  3'd0, F1, R, 3'd0, F1, 3'd0, 3'd0, 1, 1, "uni_addi");
        1: drive(1, LD, 3'd2, F1, R, 3'd0, F1, 3'd0, 3'd0, 1, 1, "uni_load");
        2: drive(1, ST, 3'd2, F0, R, 3'd0, F1, 3'd0, 3'd0, 1, 1, "uni_store");
        default: drive(1, JR, 3'd5, F1, R, 3'd0, F1, 3'd0, 3'd0, 1, 1, "uni_jalr");
      endcase
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL scoreboard_empty"); end
      else begin
        e = sb_q.pop_front(); nm = name_q.pop_front(); checks += 5;
        if (ALUOpA !== e.a) begin errors++; $display("FAIL %s ALUOpA got=%b exp=%b", nm, ALUOpA, e.a); end
        if (ALUOpB !== e.b) begin errors++; $display("FAIL %s ALUOpB got=%b exp=%b", nm, ALUOpB, e.b); end
        if (ALUCtrl !== {e.a, e.b}) begin errors++; $display("FAIL %s ALUCtrl got=%b exp=%b", nm, ALUCtrl, {e.a, e.b}); end
        if (ALUSrcA !== e.sa) begin errors++; $display("FAIL %s ALUSrcA got=%b exp=%b", nm, ALUSrcA, e.sa); end
        if (ALUSrcB !== e.sb) begin errors++; $display("FAIL %s ALUSrcB got=%b exp=%b", nm, ALUSrcB, e.sb); end
      end
    end
  endtask

  task automatic test_unified_shift;
    exp_t e; string nm;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1, R, 3'd1, F0, I, 3'd7, F0, 3'd2, 3'd2, 0, 0, "uni_sll");
        1: drive(1, R, 3'd5, F0, I, 3'd7, F0, 3'd3, 3'd3, 0, 0, "uni_srl");
        default: drive(1, R, 3'd5, F1, I, 3'd7, F0, 3'd4, 3'd4, 0, 0, "uni_sra");
      endcase
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL scoreboard_empty"); end
      else begin
        e = sb_q.pop_front(); nm = name_q.pop_front(); checks += 5;
        if (ALUOpA !== e.a) begin errors++; $display("FAIL %s ALUOpA got=%b exp=%b", nm, ALUOpA, e.a); end
        if (ALUOpB !== e.b) begin errors++; $display("FAIL %s ALUOpB got=%b exp=%b", nm, ALUOpB, e.b); end
        if (ALUCtrl !== {e.a, e.b}) begin errors++; $display("FAIL %s ALUCtrl got=%b exp=%b", nm, ALUCtrl, {e.a, e.b}); end
        if (ALUSrcA !== e.sa) begin errors++; $display("FAIL %s ALUSrcA got=%b exp=%b", nm, ALUSrcA, e.sa); end
        if (ALUSrcB !== e.sb) begin errors++; $display("FAIL %s ALUSrcB got=%b exp=%b", nm, ALUSrcB, e.sb); end
      end
    end
  endtask

  task automatic test_split;
    exp_t e; string nm;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(0, R,  3'd0, F0, R,  3'd0, F1, 3'd0, 3'd1, 0, 0, "split_add_sub");
        1: drive(0, R,  3'd1, F0, R,  3'd5, F0, 3'd2, 3'd3, 0, 0, "split_sll_srl");
        2: drive(0, R,  3'd5, F1, I,  3'd0, F0, 3'd4, 3'd0, 0, 1, "split_sra_addi");
        3: drive(0, LD, 3'd2, F0, ST, 3'd2, F0, 3'd0, 3'd0, 1, 1, "split_load_store");
        default: drive(0, LD, 3'd2, F0, NP, 3'd0, F0, 3'd0, 3'd0, 1, 0, "split_load_nop");
      endcase
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL scoreboard_empty"); end
      else begin
        e = sb_q.pop_front(); nm = name_q.pop_front(); checks += 5;
        if (ALUOpA !== e.a) begin errors++; $display("FAIL %s ALUOpA got=%b exp=%b", nm, ALUOpA, e.a); end
        if (ALUOpB !== e.b) begin errors++; $display("FAIL %s ALUOpB got=%b exp=%b", nm, ALUOpB, e.b); end
        if (ALUCtrl !== {e.a, e.b}) begin errors++; $display("FAIL %s ALUCtrl got=%b exp=%b", nm, ALUCtrl, {e.a, e.b}); end
        if (ALUSrcA !== e.sa) begin errors++; $display("FAIL %s ALUSrcA got=%b exp=%b", nm, ALUSrcA, e.sa); end
        if (ALUSrcB !== e.sb) begin errors++; $display("FAIL %s ALUSrcB got=%b exp=%b", nm, ALUSrcB, e.sb); end
      end
    end
  endtask

  task automatic test_funct_edges;
    exp_t e; string nm;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(0, R, 3'd2, F1, R, 3'd3, F0, 3'd0, 3'd0, 0, 0, "edge_slt_sltu");
        1: drive(0, R, 3'd4, F0, R, 3'd6, F0, 3'd5, 3'd6, 0, 0, "edge_xor_or");
        2: drive(0, R, 3'd7, F0, I, 3'd0, F1, 3'd7, 3'd0, 0, 1, "edge_and_addi_f7");
        3: drive(0, I, 3'd5, F1, I, 3'd5, F0, 3'd4, 3'd3, 1, 1, "edge_srai_srli");
        4: drive(0, 7'b1111111, 3'd0, F1, R, 3'd0, 7'b0000001, 3'd0, 3'd0, 0, 0, "edge_unknown_f7lsb");
        default: drive(0, I, 3'd4, F0, I, 3'd1, F0, 3'd5, 3'd2, 1, 1, "edge_xori_slli");
      endcase
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL scoreboard_empty"); end
      else begin
        e = sb_q.pop_front(); nm = name_q.pop_front(); checks += 5;
        if (ALUOpA !== e.a) begin errors++; $display("FAIL %s ALUOpA got=%b exp=%b", nm, ALUOpA, e.a); end
        if (ALUOpB !== e.b) begin errors++; $display("FAIL %s ALUOpB got=%b exp=%b", nm, ALUOpB, e.b); end
        if (ALUCtrl !== {e.a, e.b}) begin errors++; $display("FAIL %s ALUCtrl got=%b exp=%b", nm, ALUCtrl, {e.a, e.b}); end
        if (ALUSrcA !== e.sa) begin errors++; $display("FAIL %s ALUSrcA got=%b exp=%b", nm, ALUSrcA, e.sa); end
        if (ALUSrcB !== e.sb) begin errors++; $display("FAIL %s ALUSrcB got=%b exp=%b", nm, ALUSrcB, e.sb); end
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e; string nm;
    logic [6:0] opc_tab [7];
    logic [6:0] oa, ob, fa7, fb7;
    logic [2:0] fa, fb;
    logic       m;
    logic [3:0] ra, rb;
    opc_tab[0] = R; opc_tab[1] = I; opc_tab[2] = LD; opc_tab[3] = ST;
    opc_tab[4] = JR; opc_tab[5] = NP; opc_tab[6] = 7'b1110011;
    for (int i = 0; i < 60; i++) begin
      m   = 1'($urandom_range(0, 1));
      oa  = opc_tab[$urandom_range(0, 6)];
      ob  = opc_tab[$urandom_range(0, 6)];
      fa  = 3'($urandom_range(0, 7));
      fb  = 3'($urandom_range(0, 7));
      fa7 = ($urandom_range(0, 1) != 0) ? F1 : 7'($urandom_range(0, 127));
      fb7 = ($urandom_range(0, 1) != 0) ? F0 : 7'($urandom_range(0, 127));
      ra  = ref_lane(oa, fa, fa7);
      rb  = m ? ra : ref_lane(ob, fb, fb7);
      drive(m, oa, fa, fa7, ob, fb, fb7, ra[3:1], rb[3:1], ra[0], rb[0], $sformatf("b2b_%0d", i));
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL scoreboard_empty"); end
      else begin
        e = sb_q.pop_front(); nm = name_q.pop_front(); checks += 5;
        if (ALUOpA !== e.a) begin errors++; $display("FAIL %s ALUOpA got=%b exp=%b", nm, ALUOpA, e.a); end
        if (ALUOpB !== e.b) begin errors++; $display("FAIL %s ALUOpB got=%b exp=%b", nm, ALUOpB, e.b); end
        if (ALUCtrl !== {e.a, e.b}) begin errors++; $display("FAIL %s ALUCtrl got=%b exp=%b", nm, ALUCtrl, {e.a, e.b}); end
        if (ALUSrcA !== e.sa) begin errors++; $display("FAIL %s ALUSrcA got=%b exp=%b", nm, ALUSrcA, e.sa); end
        if (ALUSrcB !== e.sb) begin errors++; $display("FAIL %s ALUSrcB got=%b exp=%b", nm, ALUSrcB, e.sb); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unified_rtype();
    test_unified_imm();
    test_unified_shift();
    test_split();
    test_funct_edges();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
